// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register carrying a control field and a data field
// under a valid/ready handshake. Supports synchronous flush (bubble insertion),
// back-pressure stall, and an optional 2-entry skid buffer that registers
// ready_o so the upstream ready path does not depend on ready_i.
module pipe_stage_elastic #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 160,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occupancy_o
);

    // Encoding equals the number of held beats, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    logic in_fire, out_fire;
    logic load_in;    // main <- upstream beat
    logic load_skid;  // skid <- upstream beat
    logic pop_skid;   // main <- skid
    logic drain;      // main emptied without replacement

    assign valid_o     = (state_q != ST_EMPTY);
    assign occupancy_o = state_q;
    assign ctrl_o      = main_ctrl_q;
    assign data_o      = main_data_q;

    // With SKID=0 ready_o follows ready_i, so ONE+in_fire always implies
    // out_fire and FULL is unreachable; the shared FSM below covers both modes.
    assign ready_o  = (SKID != 0) ? (state_q != ST_FULL) : (ready_i | ~valid_o);
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    // Next-state and register load selects; flush overrides every transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        load_in   = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        drain     = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    load_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    drain   = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d  = ST_ONE;
                    pop_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Control registers: zeroed on reset, on flush, and whenever main empties.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payload registers are reset as well because an empty stage must
        // present zero control/data; they are only two entries, not a RAM.
        if (!rst_n) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush_i) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_in) begin
                main_ctrl_q <= ctrl_i;
            end else if (pop_skid) begin
                main_ctrl_q <= skid_ctrl_q;
            end else if (drain) begin
                main_ctrl_q <= '0;
            end
            if (load_skid) begin
                skid_ctrl_q <= ctrl_i;
            end
        end
    end

    // Data registers: zeroed on reset; cleared on flush/drain only with CLEAR_DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            skid_data_q <= '0;
        end else if (flush_i) begin
            if (CLEAR_DATA != 0) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            if (load_in) begin
                main_data_q <= data_i;
            end else if (pop_skid) begin
                main_data_q <= skid_data_q;
            end else if (drain && (CLEAR_DATA != 0)) begin
                main_data_q <= '0;
            end
            if (load_skid) begin
                skid_data_q <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: a skid instance with a
// scoreboard on its handshake, plus a SKID=0 and a CLEAR_DATA=0 instance.
module tb_pipe_stage_elastic;

    localparam int CW = 16;
    localparam int DW = 160;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Main instance (SKID=1, CLEAR_DATA=1)
    logic          flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic [CW-1:0] ctrl_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          ready_o, valid_o;
    logic [CW-1:0] ctrl_o;
    logic [DW-1:0] data_o;
    logic [1:0]    occupancy_o;

    // SKID=0 instance
    logic          z_flush = 1'b0, z_valid = 1'b0, z_ready = 1'b0;
    logic [CW-1:0] z_ctrl = '0;
    logic [DW-1:0] z_data = '0;
    logic          z_ready_o, z_valid_o;
    logic [CW-1:0] z_ctrl_o;
    logic [DW-1:0] z_data_o;
    logic [1:0]    z_occ;

    // CLEAR_DATA=0 instance
    logic          n_flush = 1'b0, n_valid = 1'b0, n_ready = 1'b0;
    logic [CW-1:0] n_ctrl = '0;
    logic [DW-1:0] n_data = '0;
    logic          n_ready_o, n_valid_o;
    logic [CW-1:0] n_ctrl_o;
    logic [DW-1:0] n_data_o;
    logic [1:0]    n_occ;

    int tests = 0;
    int fails = 0;
    logic [CW+DW-1:0] sb_q[$];

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
        .ctrl_o(ctrl_o), .data_o(data_o), .occupancy_o(occupancy_o)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .flush_i(z_flush), .valid_i(z_valid), .ready_o(z_ready_o),
        .ctrl_i(z_ctrl), .data_i(z_data), .valid_o(z_valid_o), .ready_i(z_ready),
        .ctrl_o(z_ctrl_o), .data_o(z_data_o), .occupancy_o(z_occ)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush_i(n_flush), .valid_i(n_valid), .ready_o(n_ready_o),
        .ctrl_i(n_ctrl), .data_i(n_data), .valid_o(n_valid_o), .ready_i(n_ready),
        .ctrl_o(n_ctrl_o), .data_o(n_data_o), .occupancy_o(n_occ)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
        return {10{c ^ 16'hA5A5}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c);
        valid_i = v;
        ctrl_i  = c;
        data_i  = mk_data(c);
    endtask

    // Scoreboard: push accepted beats, pop and compare delivered beats.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (valid_o && ready_i) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected_beat: got ctrl=%h with no beat expected", ctrl_o);
                end else begin
                    logic [CW+DW-1:0] exp_beat;
                    exp_beat = sb_q.pop_front();
                    if ({ctrl_o, data_o} !== exp_beat) begin
                        fails++;
                        $display("FAIL sb_beat: got %h expected %h", {ctrl_o, data_o}, exp_beat);
                    end
                end
            end
            if (flush_i) sb_q.delete();
            else if (valid_i && ready_o) sb_q.push_back({ctrl_i, data_i});
        end
    end

    // Reset drops every held beat.
    initial forever begin
        @(negedge rst_n);
        sb_q.delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({valid_o, occupancy_o, ready_o} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_flags: got v/occ/rdy=%b expected 0001", {valid_o, occupancy_o, ready_o});
        end
        tests++;
        if ({ctrl_o, data_o} !== '0) begin
            fails++;
            $display("FAIL reset_payload: got %h expected 0", {ctrl_o, data_o});
        end
        tests++;
        if ({z_valid_o, z_ready_o, n_valid_o, n_ready_o} !== 4'b0101) begin
            fails++;
            $display("FAIL reset_variants: got %b expected 0101", {z_valid_o, z_ready_o, n_valid_o, n_ready_o});
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if ({valid_o, ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL reset_release: got v/rdy=%b expected 01", {valid_o, ready_o});
        end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i));
            @(negedge clk);
            tests++;
            if (ready_o !== 1'b1) begin
                fails++;
                $display("FAIL stream_ready[%0d]: got %b expected 1", i, ready_o);
            end
            tick();
            tests++;
            if ({valid_o, occupancy_o, ctrl_o} !== {1'b1, 2'd1, 16'(i)}) begin
                fails++;
                $display("FAIL stream_out[%0d]: got v=%b occ=%0d ctrl=%h expected 1/1/%h",
                         i, valid_o, occupancy_o, ctrl_o, 16'(i));
            end
        end
        drive(1'b0, '0);
        tick();
        tests++;
        if ({valid_o, occupancy_o} !== 3'b000) begin
            fails++;
            $display("FAIL stream_drain: got v=%b occ=%0d expected 0/0", valid_o, occupancy_o);
        end
    endtask

    task automatic test_stall_skid();
        ready_i = 1'b0;
        drive(1'b1, 16'h00A1);
        tick();
        tests++;
        if ({occupancy_o, ctrl_o, ready_o} !== {2'd1, 16'h00A1, 1'b1}) begin
            fails++;
            $display("FAIL stall_a: got occ=%0d ctrl=%h rdy=%b expected 1/00a1/1", occupancy_o, ctrl_o, ready_o);
        end
        drive(1'b1, 16'h00B2);
        tick();
        tests++;
        if ({occupancy_o, ctrl_o, ready_o, valid_o} !== {2'd2, 16'h00A1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL stall_full: got occ=%0d ctrl=%h rdy=%b v=%b expected 2/00a1/0/1",
                     occupancy_o, ctrl_o, ready_o, valid_o);
        end
        drive(1'b1, 16'h00C3);
        tick();
        tests++;
        if ({occupancy_o, ctrl_o, ready_o} !== {2'd2, 16'h00A1, 1'b0}) begin
            fails++;
            $display("FAIL stall_hold: got occ=%0d ctrl=%h rdy=%b expected 2/00a1/0", occupancy_o, ctrl_o, ready_o);
        end
        ready_i = 1'b1;
        tick();
        tests++;
        if ({occupancy_o, ctrl_o, ready_o} !== {2'd1, 16'h00B2, 1'b1}) begin
            fails++;
            $display("FAIL stall_b: got occ=%0d ctrl=%h rdy=%b expected 1/00b2/1", occupancy_o, ctrl_o, ready_o);
        end
        tick();
        tests++;
        if ({valid_o, ctrl_o} !== {1'b1, 16'h00C3}) begin
            fails++;
            $display("FAIL stall_c: got v=%b ctrl=%h expected 1/00c3", valid_o, ctrl_o);
        end
        drive(1'b0, '0);
        tick();
        tests++;
        if ({valid_o, occupancy_o} !== 3'b000) begin
            fails++;
            $display("FAIL stall_drain: got v=%b occ=%0d expected 0/0", valid_o, occupancy_o);
        end
    endtask

    task automatic test_flush();
        // Flush while empty with an accepted beat: the beat is discarded.
        ready_i = 1'b1;
        flush_i = 1'b1;
        drive(1'b1, 16'hFFFF);
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0);
        tests++;
        if ({valid_o, occupancy_o, ctrl_o} !== {1'b0, 2'd0, 16'h0000}) begin
            fails++;
            $display("FAIL flush_empty: got v=%b occ=%0d ctrl=%h expected 0/0/0000", valid_o, occupancy_o, ctrl_o);
        end
        // Flush while FULL.
        ready_i = 1'b0;
        drive(1'b1, 16'h0011);
        tick();
        drive(1'b1, 16'h0022);
        tick();
        tests++;
        if (occupancy_o !== 2'd2) begin
            fails++;
            $display("FAIL flush_prefull: got occ=%0d expected 2", occupancy_o);
        end
        flush_i = 1'b1;
        valid_i = 1'b1;
        ctrl_i  = 16'hFFFF;
        data_i  = {10{16'hDEAD}};
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0);
        tests++;
        if ({valid_o, occupancy_o, ready_o} !== 4'b0001) begin
            fails++;
            $display("FAIL flush_full_flags: got v/occ/rdy=%b expected 0001", {valid_o, occupancy_o, ready_o});
        end
        tests++;
        if ({ctrl_o, data_o} !== '0) begin
            fails++;
            $display("FAIL flush_full_payload: got %h expected 0", {ctrl_o, data_o});
        end
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (valid_o !== 1'b0) begin
                fails++;
                $display("FAIL flush_no_ghost[%0d]: got v=%b expected 0", i, valid_o);
            end
        end
    endtask

    task automatic test_clear_data0();
        n_ready = 1'b0;
        n_valid = 1'b1;
        n_ctrl  = 16'h0033;
        n_data  = mk_data(16'h0033);
        tick();
        n_valid = 1'b0;
        tests++;
        if ({n_valid_o, n_data_o} !== {1'b1, mk_data(16'h0033)}) begin
            fails++;
            $display("FAIL nc_load: got v=%b data=%h expected 1/%h", n_valid_o, n_data_o, mk_data(16'h0033));
        end
        n_flush = 1'b1;
        tick();
        n_flush = 1'b0;
        tests++;
        if ({n_valid_o, n_occ, n_ctrl_o} !== {1'b0, 2'd0, 16'h0000}) begin
            fails++;
            $display("FAIL nc_flush_ctrl: got v=%b occ=%0d ctrl=%h expected 0/0/0000", n_valid_o, n_occ, n_ctrl_o);
        end
        tests++;
        if (n_data_o !== mk_data(16'h0033)) begin
            fails++;
            $display("FAIL nc_flush_data: got %h expected %h", n_data_o, mk_data(16'h0033));
        end
    endtask

    task automatic test_skid0();
        z_ready = 1'b0;
        z_valid = 1'b1;
        z_ctrl  = 16'h0A0A;
        z_data  = mk_data(16'h0A0A);
        #1;
        tests++;
        if (z_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL z_ready_empty: got %b expected 1", z_ready_o);
        end
        tick();
        z_ctrl = 16'h0B0B;
        z_data = mk_data(16'h0B0B);
        #1;
        tests++;
        if ({z_valid_o, z_ctrl_o, z_ready_o} !== {1'b1, 16'h0A0A, 1'b0}) begin
            fails++;
            $display("FAIL z_stall: got v=%b ctrl=%h rdy=%b expected 1/0a0a/0", z_valid_o, z_ctrl_o, z_ready_o);
        end
        tick();
        tests++;
        if (z_ctrl_o !== 16'h0A0A) begin
            fails++;
            $display("FAIL z_hold: got ctrl=%h expected 0a0a", z_ctrl_o);
        end
        z_ready = 1'b1;
        #1;
        tests++;
        if (z_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL z_ready_comb: got %b expected 1", z_ready_o);
        end
        tick();
        tests++;
        if ({z_valid_o, z_occ, z_ctrl_o, z_data_o} !== {1'b1, 2'd1, 16'h0B0B, mk_data(16'h0B0B)}) begin
            fails++;
            $display("FAIL z_load_b: got v=%b occ=%0d ctrl=%h expected 1/1/0b0b", z_valid_o, z_occ, z_ctrl_o);
        end
        z_ctrl = 16'h0C0C;
        z_data = mk_data(16'h0C0C);
        tick();
        tests++;
        if (z_ctrl_o !== 16'h0C0C) begin
            fails++;
            $display("FAIL z_stream_c: got ctrl=%h expected 0c0c", z_ctrl_o);
        end
        z_valid = 1'b0;
        tick();
        tests++;
        if ({z_valid_o, z_occ, z_ctrl_o} !== {1'b0, 2'd0, 16'h0000}) begin
            fails++;
            $display("FAIL z_drain: got v=%b occ=%0d ctrl=%h expected 0/0/0000", z_valid_o, z_occ, z_ctrl_o);
        end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        drive(1'b1, 16'h0044);
        tick();
        drive(1'b1, 16'h0055);
        tick();
        drive(1'b0, '0);
        tests++;
        if (occupancy_o !== 2'd2) begin
            fails++;
            $display("FAIL arst_prefull: got occ=%0d expected 2", occupancy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({valid_o, occupancy_o, ready_o} !== 4'b0001) begin
            fails++;
            $display("FAIL arst_flags: got v/occ/rdy=%b expected 0001", {valid_o, occupancy_o, ready_o});
        end
        tests++;
        if ({ctrl_o, data_o} !== '0) begin
            fails++;
            $display("FAIL arst_payload: got %h expected 0", {ctrl_o, data_o});
        end
        rst_n = 1'b1;
        tick();
        ready_i = 1'b1;
        drive(1'b1, 16'h0066);
        tick();
        drive(1'b0, '0);
        tests++;
        if ({valid_o, ctrl_o, data_o} !== {1'b1, 16'h0066, mk_data(16'h0066)}) begin
            fails++;
            $display("FAIL arst_first_beat: got v=%b ctrl=%h expected 1/0066", valid_o, ctrl_o);
        end
        tick();
        tests++;
        if (valid_o !== 1'b0) begin
            fails++;
            $display("FAIL arst_drain: got v=%b expected 0", valid_o);
        end
    endtask

    task automatic test_scoreboard_empty();
        repeat (2) tick();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d undelivered beats expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_clear_data0();
        test_skid0();
        test_async_reset();
        test_scoreboard_empty();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
